// File: rtl/fourbit_fa_str_pkg.sv
// Shared constants for the structural 4-bit ripple-carry adder.
//   AdderWidth : operand and sum width of fourbit_fa_str (fixed at 4).
package fourbit_fa_str_pkg;

  localparam int AdderWidth = 4;

endpackage

// File: rtl/full_adder_str.sv
// One-bit gate-level full adder, built only from primitives.
// Ports:
//   a, b  : operand bits
//   cin   : carry in
//   s     : sum bit, a ^ b ^ cin
//   cout  : carry out, (a & b) | (cin & (a ^ b))
module full_adder_str (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic aXorB;
  logic aAndB;
  logic carryProp;

  // The propagate term a ^ b is shared between the sum and the carry,
  // so the carry only passes through cin when exactly one operand is set.
  xor gXorAb  (aXorB, a, b);
  xor gXorSum (s, aXorB, cin);
  and gAndGen (aAndB, a, b);
  and gAndProp(carryProp, cin, aXorB);
  or  gOrCout (cout, aAndB, carryProp);

endmodule

// File: rtl/fourbit_fa_str.sv
// Structural 4-bit ripple-carry adder with a registered copy of the result.
// Ports:
//   clk    : clock, rising edge; drives only the output registers
//   rst    : synchronous active-high reset for S_q/Cout_q
//   A, B   : unsigned 4-bit operands, bit 0 is the LSB
//   Cin    : carry into bit 0
//   S      : combinational sum, (A + B + Cin) mod 16
//   Cout   : combinational carry out of bit 3
//   S_q    : S registered on the rising edge of clk
//   Cout_q : Cout registered on the rising edge of clk
module fourbit_fa_str
  import fourbit_fa_str_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AdderWidth-1:0] A,
  input  logic [AdderWidth-1:0] B,
  input  logic                  Cin,
  output logic [AdderWidth-1:0] S,
  output logic                  Cout,
  output logic [AdderWidth-1:0] S_q,
  output logic                  Cout_q
);

  logic [AdderWidth:0] c;

  assign c[0] = Cin;

  // Four ripple stages; each carry out feeds the next stage's carry in,
  // so the worst-case path runs from Cin through all four carries.
  full_adder_str stage0 (.a(A[0]), .b(B[0]), .cin(c[0]), .s(S[0]), .cout(c[1]));
  full_adder_str stage1 (.a(A[1]), .b(B[1]), .cin(c[1]), .s(S[1]), .cout(c[2]));
  full_adder_str stage2 (.a(A[2]), .b(B[2]), .cin(c[2]), .s(S[2]), .cout(c[3]));
  full_adder_str stage3 (.a(A[3]), .b(B[3]), .cin(c[3]), .s(S[3]), .cout(c[4]));

  assign Cout = c[4];

  // Output register for synchronous consumers. Reset clears only these
  // flops; the combinational S/Cout keep following the inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      S_q    <= '0;
      Cout_q <= 1'b0;
    end else begin
      S_q    <= S;
      Cout_q <= Cout;
    end
  end

endmodule

// File: tb/tb_fourbit_fa_str.sv
module tb_fourbit_fa_str;

  logic       clk;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;
  logic [3:0] S;
  logic       Cout;
  logic [3:0] S_q;
  logic       Cout_q;

  int vectorCount;
  int missCount;

  logic [4:0] expQ[$];

  fourbit_fa_str dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .B      (B),
    .Cin    (Cin),
    .S      (S),
    .Cout   (Cout),
    .S_q    (S_q),
    .Cout_q (Cout_q)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: plain 5-bit unsigned addition of the operands.
  function automatic logic [4:0] refSum(input logic [3:0] a, input logic [3:0] b,
                                        input logic cin);
    int total;
    total = int'(a) + int'(b) + int'(cin);
    return total[4:0];
  endfunction

  // Compares the combinational outputs against the model right after the
  // inputs settle.
  task automatic checkOutput(input string name, input logic [4:0] expected);
    if ({Cout, S} !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: A=%b B=%b Cin=%b got {Cout,S}=%b expected %b",
               name, A, B, Cin, {Cout, S}, expected);
    end
  endtask

  // Drives one vector away from the active edge, checks the combinational
  // result, and queues the value the registers must show after the next edge.
  task automatic applyStimulus(input string name, input logic [3:0] a, input logic [3:0] b,
                               input logic cin, input logic r);
    logic [4:0] expected;
    @(negedge clk);
    A   = a;
    B   = b;
    Cin = cin;
    rst = r;
    vectorCount++;
    expected = refSum(a, b, cin);
    #1;
    checkOutput(name, expected);
    expQ.push_back(r ? 5'd0 : expected);
  endtask

  // Monitor: after every rising edge, one queued expectation is due on the
  // registered outputs.
  always @(posedge clk) begin
    logic [4:0] expected;
    #1;
    if (expQ.size() > 0) begin
      expected = expQ.pop_front();
      if ({Cout_q, S_q} !== expected) begin
        missCount++;
        $display("[TB] FAIL registered: got {Cout_q,S_q}=%b expected %b",
                 {Cout_q, S_q}, expected);
      end
    end
  end

  initial begin
    vectorCount = 0;
    missCount   = 0;
    rst = 1'b1;
    A   = 4'd0;
    B   = 4'd0;
    Cin = 1'b0;

    $display("[TB] reset and directed vectors");
    applyStimulus("reset0", 4'b0101, 4'b0011, 1'b0, 1'b1);
    applyStimulus("reset1", 4'b1001, 4'b0110, 1'b1, 1'b1);
    applyStimulus("dir_0_10", 4'b0000, 4'b1010, 1'b0, 1'b0);
    applyStimulus("dir_ff_c0", 4'b1111, 4'b1111, 1'b0, 1'b0);
    applyStimulus("dir_ff_c1", 4'b1111, 4'b1111, 1'b1, 1'b0);
    applyStimulus("dir_ae_c0", 4'b1010, 4'b1110, 1'b0, 1'b0);
    applyStimulus("dir_ae_c1", 4'b1010, 4'b1110, 1'b1, 1'b0);
    applyStimulus("ripple_c0", 4'b1111, 4'b0000, 1'b0, 1'b0);
    applyStimulus("ripple_c1", 4'b1111, 4'b0000, 1'b1, 1'b0);

    $display("[TB] exhaustive sweep");
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      applyStimulus("sweep", v[8:5], v[4:1], v[0], 1'b0);
    end

    $display("[TB] random vectors");
    for (int i = 0; i < 200; i++) begin
      applyStimulus("random", 4'($urandom_range(15)), 4'($urandom_range(15)),
                    1'($urandom_range(1)), 1'b0);
    end

    $display("[TB] mid-stream reset");
    applyStimulus("midrst0", 4'b1111, 4'b1111, 1'b1, 1'b1);
    applyStimulus("midrst1", 4'b1111, 4'b1111, 1'b1, 1'b1);
    applyStimulus("postrst", 4'b1111, 4'b1111, 1'b1, 1'b0);
    applyStimulus("postrst2", 4'b0011, 4'b0100, 1'b0, 1'b0);

    for (int i = 0; i < 5 && expQ.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (expQ.size() != 0) begin
      missCount++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
